cpu_run_monitor: RTL
====================

Name: cpu_run_monitor

Overview:
- Synthesizable run controller and trace monitor that sits beside CPU_Top on the instruction-address and data-memory write buses.
- Replaces the fixed "$time > 700" stop and $display tracing with parametrised cycle-limit timeout, halt detection and a store-write log FIFO with a running signature.
- Usable in simulation and on FPGA; the host or bench drains the log through a pop interface.

Parameters:
DATA_WIDTH, 32, width of write_data and log data.
ADDR_WIDTH, 8, width of instruction_address and data_address.
LOG_DEPTH, 16, write-log FIFO entries; power of two, at least 2.
MAX_CYCLES, 40, RUN cycles before timeout (40 x 17.5 = 700 time units).
HALT_STABLE, 4, consecutive cycles with unchanged instruction_address that declare a halt; at least 2.
COUNT_WIDTH, 16, width of cycle_count and write_count.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse; begins or restarts a run.
instruction_address  in  ADDR_WIDTH  CPU fetch address.
data_address  in  ADDR_WIDTH  CPU data address.
write_data  in  DATA_WIDTH  CPU store data.
write_enable  in  1  CPU store strobe.
log_rd_en  in  1  pop request for the write log.
running  out  1  high while in RUN.
done  out  1  high in HALTED or TIMEOUT.
halted  out  1  high in HALTED.
timeout  out  1  high in TIMEOUT.
cycle_count  out  COUNT_WIDTH  RUN cycles elapsed.
write_count  out  COUNT_WIDTH  stores observed; saturates at all-ones.
signature  out  DATA_WIDTH  running checksum of the stores.
log_valid  out  1  one-cycle pulse; log_addr and log_data are valid.
log_addr  out  ADDR_WIDTH  popped store address.
log_data  out  DATA_WIDTH  popped store data.
log_empty  out  1  FIFO empty.
log_full  out  1  FIFO full.
log_overflow  out  1  sticky; at least one store was dropped.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; every output 0 except log_empty=1; FIFO pointers 0; stable counter 0; last-PC register 0.
- State machine: IDLE, RUN, HALTED, TIMEOUT.
- start in any state (also in RUN) → RUN on the next edge.
  - Same edge clears cycle_count, write_count, signature, log_overflow, the FIFO and the stable counter.
  - Same edge loads last-PC with instruction_address.
  - A store on the start cycle is not logged.
- In RUN, every cycle:
  - cycle_count increments by 1.
  - If instruction_address equals last-PC, the stable counter increments; otherwise it clears and last-PC updates.
- Halt: when the stable counter reaches HALTED_STABLE-1 (i.e. HALT_STABLE equal consecutive samples), go to HALTED.
- Timeout: when cycle_count reaches MAX_CYCLES-1 while incrementing (MAX_CYCLES RUN cycles total), go to TIMEOUT.
- If halt and timeout fire in the same cycle, HALTED wins.
- HALTED and TIMEOUT hold all counters; leave only on start or reset.
- Store capture (RUN only, write_enable=1):
  - Push {data_address, write_data} into the FIFO.
  - write_count +1, saturating.
  - signature updates to rotl1(signature) XOR write_data XOR zero-extended data_address. Signature and count update even if the push is dropped.
- FIFO full and push without a simultaneous pop: entry dropped, log_overflow set.
- FIFO full with push and pop in the same cycle: both succeed, no drop.
- Pop: log_rd_en while not empty → log_valid pulses for 1 cycle on the next edge with the oldest entry (1-cycle latency). log_rd_en while empty is ignored, no pulse.
- Pops work in every state, including IDLE/HALTED/TIMEOUT.
- Pointers are log2(LOG_DEPTH)+1 bits and wrap naturally; full/empty come from the MSB compare.
- log_addr and log_data hold their last value between pops.
- Mid-run reset: immediate return to reset values; the FIFO contents are discarded.

Test Plan:
- Reset held 3 cycles, then start; PC increments 0,4,8,… forever → timeout=1 after 40 RUN cycles, cycle_count=40 (0x28), halted=0.
- PC sequence 0,4,8,8,8,8 → halted=1 on the edge after the 4th sample of 8; cycle_count frozen; done=1.
- PC stabilises on exactly cycle 40 → halted=1, timeout=0.
- Three stores (0x10,0xA), (0x14,0xB), (0x18,0xC), then pop 3 times → log_valid pulses return them in order; write_count=3; signature equals the reference model value; log_empty=1 afterwards.
- 17 stores with no pops and LOG_DEPTH=16 → log_full=1, log_overflow=1, write_count=17; 16 pops return stores 1..16.
- Reset asserted mid-run after 5 stores → all outputs 0 and log_empty=1 immediately, without waiting for a clock edge; a start after release begins a clean run.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run controller with cycle-limit timeout, halt detection,
// store-write log FIFO and running store signature.
module cpu_run_monitor #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int LOG_DEPTH   = 16,
    parameter int MAX_CYCLES  = 40,
    parameter int HALT_STABLE = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  instruction_address,
    input  logic [ADDR_WIDTH-1:0]  data_address,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   write_enable,
    input  logic                   log_rd_en,
    output logic                   running,
    output logic                   done,
    output logic                   halted,
    output logic                   timeout,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] write_count,
    output logic [DATA_WIDTH-1:0]  signature,
    output logic                   log_valid,
    output logic [ADDR_WIDTH-1:0]  log_addr,
    output logic [DATA_WIDTH-1:0]  log_data,
    output logic                   log_empty,
    output logic                   log_full,
    output logic                   log_overflow
);
    localparam int PW = $clog2(LOG_DEPTH) + 1;
    localparam int SW = $clog2(HALT_STABLE) + 1;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] HALTED  = 2'd2;
    localparam logic [1:0] TIMEOUT = 2'd3;

    logic [1:0]                       state;
    logic [PW-1:0]                    wr_ptr, rd_ptr;
    logic [SW-1:0]                    stable;
    logic [ADDR_WIDTH-1:0]            last_pc;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [LOG_DEPTH];
    logic                             is_run, pc_same, halt_hit, limit_hit, store, do_pop, do_push;

    always_comb begin
        is_run    = state == RUN;
        pc_same   = instruction_address == last_pc;
        halt_hit  = is_run && pc_same && stable == SW'(HALT_STABLE - 2);
        limit_hit = is_run && cycle_count == COUNT_WIDTH'(MAX_CYCLES - 1);
        store     = is_run && write_enable && !start;
        log_empty = wr_ptr == rd_ptr;
        log_full  = wr_ptr == {~rd_ptr[PW-1], rd_ptr[PW-2:0]};
        do_pop    = log_rd_en && !log_empty && !start;
        do_push   = store && (!log_full || do_pop);
        running   = state == RUN;
        halted    = state == HALTED;
        timeout   = state == TIMEOUT;
        done      = halted || timeout;
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[PW-2:0]] <= {data_address, write_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cycle_count  <= '0;
            write_count  <= '0;
            signature    <= '0;
            log_overflow <= 1'b0;
            log_valid    <= 1'b0;
            log_addr     <= '0;
            log_data     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            stable       <= '0;
            last_pc      <= '0;
        end else begin
            log_valid <= do_pop;
            if (do_pop) begin
                {log_addr, log_data} <= mem[rd_ptr[PW-2:0]];
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (start) begin
                state        <= RUN;
                cycle_count  <= '0;
                write_count  <= '0;
                signature    <= '0;
                log_overflow <= 1'b0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                stable       <= '0;
                last_pc      <= instruction_address;
            end else if (is_run) begin
                cycle_count <= cycle_count + COUNT_WIDTH'(1);
                stable      <= pc_same ? stable + SW'(1) : '0;
                if (!pc_same) last_pc <= instruction_address;
                // halt has priority when both conditions land on the same cycle
                state <= halt_hit ? HALTED : limit_hit ? TIMEOUT : RUN;
                if (write_enable) begin
                    write_count <= write_count + COUNT_WIDTH'(write_count != '1);
                    signature   <= {signature[DATA_WIDTH-2:0], signature[DATA_WIDTH-1]}
                                   ^ write_data ^ DATA_WIDTH'(data_address);
                    if (do_push) wr_ptr <= wr_ptr + PW'(1);
                    else log_overflow <= 1'b1;
                end
            end
        end
    end
endmodule
